// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive engine driven by a 16x baud tick.
// Synchronizes rxd, validates the start bit, majority-votes each bit from
// samples at ticks 7/8/9, checks parity and stop, detects breaks, and
// reports each character with a one-clk rx_valid pulse.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick_16x            one-clk strobe at 16x baud; all bit timing advances on it
//   rxd                 asynchronous serial input, idle high
//   cfg_data_bits       character length 00=5 .. 11=8
//   cfg_parity_en       parity bit follows data bits
//   cfg_parity_odd      odd (1) / even (0) parity
//   rx_data             received character, LSB-aligned, upper bits 0
//   rx_valid            one-clk pulse qualifying rx_data and flags
//   parity_err          parity mismatch
//   frame_err           stop bit sampled 0
//   break_det           all-zero character with zero stop bit
//   rx_busy             FSM is not in IDLE
module uart_rx_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_16x,
    input  logic       rxd,
    input  logic [1:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_cnt;
    logic                   r_s7;
    logic                   r_s8;
    logic [2:0]             r_idx;
    logic [7:0]             r_shift;
    logic                   r_par_bit;
    logic                   r_par_err;
    logic                   w_rxs;
    logic                   w_maj;
    logic                   w_decide;
    logic                   w_end;
    logic                   w_last;
    logic                   w_done;
    logic                   w_par_exp;

    assign w_rxs   = r_sync[SYNC_STAGES-1];
    assign rx_busy = r_state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = (tick_16x && !w_rxs) ? START : IDLE;
            START:     w_next = (w_decide && w_maj) ? IDLE : w_end ? DATA : START;
            DATA:      w_next = (w_end && w_last) ? (cfg_parity_en ? PARITY : STOP) : DATA;
            PARITY:    w_next = w_end ? STOP : PARITY;
            STOP:      w_next = w_decide ? (w_maj ? IDLE : WAIT_IDLE) : STOP;
            WAIT_IDLE: w_next = (tick_16x && w_rxs) ? IDLE : WAIT_IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Bit value uses the live cnt=9 sample alongside the two captured ones.
    always_comb begin
        w_decide  = tick_16x && r_cnt == 4'd9;
        w_end     = tick_16x && r_cnt == 4'd15;
        w_maj     = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
        w_last    = r_idx == {1'b1, cfg_data_bits};
        w_done    = r_state == STOP && w_decide;
        w_par_exp = ^r_shift ^ cfg_parity_odd;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_cnt     <= '0;
            r_s7      <= 1'b1;
            r_s8      <= 1'b1;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            // Counter restarts whenever the FSM leaves the bit states.
            if (tick_16x)
                r_cnt <= (r_state == IDLE || w_next == IDLE || w_next == WAIT_IDLE) ? 4'd0 : r_cnt + 4'd1;
            if (tick_16x && r_cnt == 4'd7) r_s7 <= w_rxs;
            if (tick_16x && r_cnt == 4'd8) r_s8 <= w_rxs;
            if (r_state == IDLE) begin
                r_idx     <= '0;
                r_shift   <= '0;
                r_par_bit <= 1'b0;
                r_par_err <= 1'b0;
            end
            if (r_state == DATA && w_decide) r_shift[r_idx] <= w_maj;
            if (r_state == DATA && w_end)    r_idx <= r_idx + 3'd1;
            if (r_state == PARITY && w_decide) begin
                r_par_bit <= w_maj;
                r_par_err <= w_maj != w_par_exp;
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_valid <= w_done;
            if (w_done) begin
                rx_data    <= r_shift;
                parity_err <= r_par_err;
                frame_err  <= !w_maj;
                break_det  <= !w_maj && r_shift == 8'd0 && !r_par_bit;
            end
        end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core.
// Ports: none (drives clk, rst_n, tick_16x, rxd and config; checks all outputs).
module tb_uart_rx_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_16x = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] cfg_data_bits = 2'b11;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       rx_busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q[$];

    uart_rx_core #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rxd(rxd),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        int t = 0;
        forever begin
            @(negedge clk);
            tick_16x = t == 3;
            t = (t + 1) % 4;
        end
    end

    function automatic logic [31:0] pk(logic bd, logic fe, logic pe, logic [7:0] d);
        return {21'd0, bd, fe, pe, d};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (rx_valid) q.push_back(pk(break_det, frame_err, parity_err, rx_data));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold_bit(input logic v, input int clks);
        rxd = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int n, input logic pen, input logic pb, input logic stop);
        hold_bit(1'b0, 64);
        for (int i = 0; i < n; i++) hold_bit(d[i], 64);
        if (pen) hold_bit(pb, 64);
        hold_bit(stop, 64);
        rxd = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_flags", 32'({parity_err, frame_err, break_det}), 0);
        chk("rst_busy", 32'(rx_busy), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        q.delete();
        send(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        repeat (64) @(negedge clk);
        chk("a5_count", 32'(q.size()), 1);
        chk("a5_frame", q[0], pk(0, 0, 0, 8'hA5));
        chk("a5_busy", 32'(rx_busy), 0);

        cfg_data_bits = 2'b10; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1;
        q.delete();
        send(8'h35, 7, 1'b1, 1'b1, 1'b1);
        repeat (32) @(negedge clk);
        send(8'h35, 7, 1'b1, 1'b0, 1'b1);
        repeat (64) @(negedge clk);
        chk("par_count", 32'(q.size()), 2);
        chk("par_good", q[0], pk(0, 0, 0, 8'h35));
        chk("par_bad", q[1], pk(0, 0, 1, 8'h35));

        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
        q.delete();
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_busy", 32'(rx_busy), 1);
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_idle", 32'(rx_busy), 0);
        repeat (200) @(negedge clk);
        chk("glitch_count", 32'(q.size()), 0);

        q.delete();
        hold_bit(1'b0, 1920);
        chk("break_busy", 32'(rx_busy), 1);
        rxd = 1'b1;
        repeat (64) @(negedge clk);
        chk("break_count", 32'(q.size()), 1);
        chk("break_frame", q[0], pk(1, 1, 0, 8'h00));
        chk("break_idle", 32'(rx_busy), 0);
        q.delete();
        send(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        repeat (64) @(negedge clk);
        chk("after_brk_count", 32'(q.size()), 1);
        chk("after_brk_frame", q[0], pk(0, 0, 0, 8'h5A));

        cfg_data_bits = 2'b00;
        q.delete();
        send(8'h1F, 5, 1'b0, 1'b0, 1'b1);
        send(8'h0A, 5, 1'b0, 1'b0, 1'b1);
        repeat (64) @(negedge clk);
        chk("b2b_count", 32'(q.size()), 2);
        chk("b2b_first", q[0], pk(0, 0, 0, 8'h1F));
        chk("b2b_second", q[1], pk(0, 0, 0, 8'h0A));

        cfg_data_bits = 2'b11;
        q.delete();
        hold_bit(1'b0, 64);
        for (int i = 0; i < 3; i++) hold_bit(1'b1, 64);
        hold_bit(1'b1, 32);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(rx_data), 0);
        chk("mid_rst_busy", 32'(rx_busy), 0);
        chk("mid_rst_valid", 32'(rx_valid), 0);
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("mid_rst_count", 32'(q.size()), 0);
        send(8'h81, 8, 1'b0, 1'b0, 1'b1);
        repeat (64) @(negedge clk);
        chk("post_rst_count", 32'(q.size()), 1);
        chk("post_rst_frame", q[0], pk(0, 0, 0, 8'h81));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
